// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and helpers for the cache refill arbiter.
package cache_pkg;
    localparam int DEF_TAGS_WIDTH     = 48;
    localparam int DEF_DATA_PORT_SIZE = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } refill_state_t;

    // Number of bits needed to hold the value v (0 for v == 0).
    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((v >> i) != 0) r = i + 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/cache_refill_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any
);
    int w_j;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_j         = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_j = (int'(i_last_grant) + i) % NUM_REQ;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_grant_idx  = ID_W'(w_j);
            end
        end
    end
endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one backend refill port among NUM_REQ cache-way requesters,
// one refill outstanding at a time, round-robin between refills.
module cache_refill_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TAGS_WIDTH     = DEF_TAGS_WIDTH,
    parameter int DATA_PORT_SIZE = DEF_DATA_PORT_SIZE,
    parameter int BEATS          = 1,
    localparam int ID_W          = (clogb2(NUM_REQ-1) > 1) ? clogb2(NUM_REQ-1) : 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_addr_tvalid,
    input  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata,
    output logic [NUM_REQ-1:0]            req_addr_tready,
    output logic [NUM_REQ-1:0]            req_data_tvalid,
    output logic [DATA_PORT_SIZE-1:0]     req_data_tdata,
    input  logic [NUM_REQ-1:0]            req_data_tready,
    output logic                          mem_addr_tvalid,
    output logic [TAGS_WIDTH-1:0]         mem_addr_tdata,
    input  logic                          mem_addr_tready,
    input  logic                          mem_data_tvalid,
    input  logic [DATA_PORT_SIZE-1:0]     mem_data_tdata,
    output logic                          mem_data_tready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);
    localparam int CNT_W = (clogb2(BEATS) > 1) ? clogb2(BEATS) : 1;

    refill_state_t         r_state;
    logic [TAGS_WIDTH-1:0] r_tag_q;
    logic                  r_mem_addr_tvalid;
    logic                  r_busy;
    logic [ID_W-1:0]       r_grant_id;
    logic [ID_W-1:0]       r_last_grant;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_win_idx;
    logic                  w_any;
    logic                  w_in_idle;
    logic                  w_in_data;
    logic                  w_addr_hs;
    logic                  w_beat_hs;
    logic [TAGS_WIDTH-1:0] w_win_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req        (req_addr_tvalid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_win_idx),
        .o_any        (w_any)
    );

    // Gating with rstn keeps the handshake outputs quiet while reset is held.
    assign w_in_idle = rstn && (r_state == ST_IDLE);
    assign w_in_data = rstn && (r_state == ST_DATA);
    assign w_addr_hs = w_in_idle && w_any;
    assign w_beat_hs = w_in_data && mem_data_tvalid && req_data_tready[r_grant_id];
    assign w_win_tag = req_addr_tdata[w_win_idx*TAGS_WIDTH +: TAGS_WIDTH];

    assign req_addr_tready = w_in_idle ? w_grant : '0;
    assign mem_data_tready = w_in_data && req_data_tready[r_grant_id];
    assign req_data_tvalid = (w_in_data && mem_data_tvalid) ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign req_data_tdata  = mem_data_tdata;

    assign mem_addr_tvalid = r_mem_addr_tvalid;
    assign mem_addr_tdata  = r_tag_q;
    assign grant_id        = r_grant_id;
    assign busy            = r_busy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state           <= ST_IDLE;
            r_tag_q           <= '0;
            r_mem_addr_tvalid <= 1'b0;
            r_busy            <= 1'b0;
            r_grant_id        <= '0;
            r_last_grant      <= ID_W'(NUM_REQ-1);
            r_beat_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_addr_hs) begin
                        r_tag_q           <= w_win_tag;
                        r_grant_id        <= w_win_idx;
                        r_mem_addr_tvalid <= 1'b1;
                        r_busy            <= 1'b1;
                        r_state           <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (mem_addr_tready) begin
                        r_mem_addr_tvalid <= 1'b0;
                        r_beat_cnt        <= '0;
                        r_state           <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_hs) begin
                        if (r_beat_cnt == CNT_W'(BEATS-1)) begin
                            r_last_grant <= r_grant_id;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
